// File: rtl/data_acquisition_ip_apb.sv
// data_acquisition_ip_apb: APB3 slave that samples one of eight sensor slots, Fast (single) or Slow (averaged)
// Ports: PCLK/PRESET clock and async reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA APB request;
//        PRDATA/PREADY/PSLVERR APB response; SensorReadings eight 16-bit sensor values.
module data_acquisition_ip_apb #(
  parameter int SLOW_SAMPLES = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [7:0][15:0] SensorReadings
);
  localparam int LG = $clog2(SLOW_SAMPLES);
  typedef enum logic [1:0] {IDLE, FAST, SLOW} state_t;
  state_t         state_q;
  logic [31:0]    cmd_q;
  logic           done_q, err_q;
  logic [15:0]    result_q;
  logic [2:0]     slot_q;
  logic [LG-1:0]  cnt_q;
  logic [15+LG:0] acc_q, acc_d;
  logic [15:0]    sample;
  logic           sel_cmd, sel_sts, sel_res, access, wr_cmd, busy, unused;
  assign busy    = state_q != IDLE;
  assign sel_cmd = PADDR[7:2] == 6'd0;
  assign sel_sts = PADDR[7:2] == 6'd1;
  assign sel_res = PADDR[7:2] == 6'd2;
  assign access  = PSEL & PENABLE;
  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~(sel_cmd | sel_sts | sel_res) | (PWRITE & (sel_sts | sel_res)));
  assign wr_cmd  = access & PWRITE & sel_cmd;
  assign sample  = SensorReadings[slot_q];
  assign acc_d   = acc_q + {{LG{1'b0}}, sample};
  assign unused  = ^PADDR[1:0];
  assign PRDATA  = (!PSEL || PWRITE) ? 32'd0 :
                   sel_cmd ? cmd_q :
                   sel_sts ? {29'd0, busy, err_q, done_q} :
                   sel_res ? {16'd0, result_q} : 32'd0;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        FAST: begin
          result_q <= sample;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        SLOW: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LG'(SLOW_SAMPLES - 1)) begin
            result_q <= acc_d[LG +: 16];
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: ;
      endcase
      // A command while busy is rejected: it only sets err, or clears it when clear=1.
      if (wr_cmd) begin
        if (busy) err_q <= ~PWDATA[0];
        else begin
          cmd_q  <= PWDATA;
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (!PWDATA[0]) begin
            slot_q <= PWDATA[28:26] + PWDATA[25:23];
            cnt_q  <= '0;
            acc_q  <= '0;
            case (PWDATA[30:29])
              2'b01:   state_q <= FAST;
              2'b10:   state_q <= SLOW;
              2'b11:   err_q   <= 1'b1;
              default: ;
            endcase
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_data_acquisition_ip_apb.sv
// tb_data_acquisition_ip_apb: directed self-checking bench for the APB data-acquisition block
module tb_data_acquisition_ip_apb;
  logic             PCLK = 1'b0, PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]       PADDR = '0;
  logic [31:0]      PWDATA = '0, PRDATA;
  logic             PREADY, PSLVERR;
  logic [7:0][15:0] SensorReadings = '0;
  int               tests = 0, fails = 0;
  logic             alt_en = 1'b0;
  logic [31:0]      d, s;
  logic             e;
  int               n;
  data_acquisition_ip_apb #(.SLOW_SAMPLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SensorReadings(SensorReadings)
  );
  always #5 PCLK = ~PCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apb_write(input logic [7:0] a, input logic [31:0] wd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask
  task automatic apb_read(input logic [7:0] a, output logic [31:0] rd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #1 rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask
  task automatic peek(output logic [31:0] st);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    #1 st = PRDATA;
    PSEL = 1'b0;
  endtask
  task automatic wait_idle(output int cyc);
    logic [31:0] st;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      peek(st);
      if (!st[2]) break;
      cyc++;
      @(posedge PCLK); #1;
      if (alt_en) SensorReadings[0] = (SensorReadings[0] == 16'd0) ? 16'd3 : 16'd0;
    end
  endtask
  initial begin
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    apb_read(8'h04, d, e); check("rst_status", d, 32'h0); check("rst_slverr", {31'd0, e}, 32'd0);
    apb_read(8'h08, d, e); check("rst_result", d, 32'h0);
    apb_read(8'h00, d, e); check("rst_cmd", d, 32'h0);
    check("pready", {31'd0, PREADY}, 32'd1);
    SensorReadings[2] = 16'h0FAB;
    apb_write(8'h00, 32'h48000000, e); check("cmd_slverr", {31'd0, e}, 32'd0);
    wait_idle(n); check("slow_busy_cycles", n, 32'd16);
    peek(s); check("slow_status", s, 32'h1);
    apb_read(8'h08, d, e); check("slow_result", d, 32'h0FAB);
    apb_read(8'h00, d, e); check("cmd_readback", d, 32'h48000000);
    SensorReadings[3] = 16'h1234;
    apb_write(8'h00, 32'h28800000, e);
    wait_idle(n); check("fast_busy_cycles", n, 32'd1);
    peek(s); check("fast_status", s, 32'h1);
    apb_read(8'h08, d, e); check("fast_result", d, 32'h1234);
    apb_write(8'h00, 32'h3D800000, e);
    wait_idle(n);
    apb_read(8'h08, d, e); check("wrap_result", d, 32'h0FAB);
    SensorReadings[0] = 16'd0; alt_en = 1'b1;
    apb_write(8'h00, 32'h40000000, e);
    wait_idle(n); alt_en = 1'b0;
    apb_read(8'h08, d, e); check("avg_trunc", d, 32'h1);
    SensorReadings[5] = 16'h0100;
    apb_write(8'h00, 32'h54000000, e);
    apb_write(8'h00, 32'h20000000, e);
    peek(s); check("busy_write_err", s, 32'h6);
    apb_read(8'h00, d, e); check("busy_cmd_kept", d, 32'h54000000);
    wait_idle(n);
    peek(s); check("busy_write_status", s, 32'h3);
    apb_read(8'h08, d, e); check("busy_write_result", d, 32'h0100);
    apb_write(8'h00, 32'h00000001, e);
    peek(s); check("clear_status", s, 32'h0);
    apb_write(8'h00, 32'h28800000, e);
    wait_idle(n);
    apb_write(8'h00, 32'h60000000, e);
    peek(s); check("mode11_status", s, 32'h2);
    apb_write(8'h00, 32'h54000000, e);
    apb_write(8'h00, 32'h20000000, e);
    apb_write(8'h00, 32'h00000001, e);
    peek(s); check("busy_clear_err", s, 32'h4);
    wait_idle(n);
    peek(s); check("busy_clear_done", s, 32'h1);
    apb_read(8'h0C, d, e); check("unmapped_slverr", {31'd0, e}, 32'd1); check("unmapped_rdata", d, 32'h0);
    apb_write(8'h08, 32'hFFFF_FFFF, e); check("wr_result_slverr", {31'd0, e}, 32'd1);
    apb_read(8'h08, d, e); check("result_unchanged", d, 32'h0100);
    apb_write(8'h04, 32'hFFFF_FFFF, e); check("wr_status_slverr", {31'd0, e}, 32'd1);
    peek(s); check("status_unchanged", s, 32'h1);
    apb_write(8'h00, 32'h40000000, e);
    repeat (3) @(posedge PCLK);
    #2 PRESET = 1'b1;
    peek(s); check("reset_mid_slow", s, 32'h0);
    apb_read(8'h00, d, e); check("reset_cmd", d, 32'h0);
    apb_read(8'h08, d, e); check("reset_result", d, 32'h0);
    PRESET = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
